sub_operand_feeder: RTL and testbench

//  Upstream stage of the 8-bit subtractor datapath. Accepts operand pairs over a valid/ready

---
 rtl/sub_pkg.sv | 12 +
 rtl/sub_sync_fifo.sv | 55 +++++
 rtl/sub_operand_feeder.sv | 68 ++++++
 tb/tb_sub_operand_feeder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types for the 8-bit subtractor datapath: operand width and the
// minuend/subtrahend pair carried through the feeder FIFO.
package sub_pkg;

  localparam int OPND_W = 8;

  typedef struct packed {
    logic [OPND_W-1:0] a;  // minuend
    logic [OPND_W-1:0] b;  // subtrahend
  } opnd_pair_t;

endpackage

// File: rtl/sub_sync_fifo.sv
// Single-clock FIFO with registered occupancy. The caller gates push and pop,
// so push only happens when not full and pop only happens when not empty.
module sub_sync_fifo
  import sub_pkg::*;
#(
  parameter  int  DEPTH = 8,
  parameter  type T     = opnd_pair_t,
  localparam int  PTR_W = $clog2(DEPTH),
  localparam int  LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  T                 wdata,
  output T                 rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: storage has no reset; the pointers and level alone decide what is
  // valid, and a resettable array would cost a flop-mux per bit for nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: every sequential assignment uses <= so all registers update from
  // pre-edge values, no matter what order the statements are written in.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;  // DEPTH is a power of 2, so this wraps
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/sub_operand_feeder.sv
// Feeder stage in front of the subtractor: buffers operand pairs and issues
// one per enabled cycle onto registered in1/in2 with an op_valid qualifier.
module sub_operand_feeder
  import sub_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [OPND_W-1:0] s_in1,
  input  logic [OPND_W-1:0] s_in2,
  input  logic              issue_en,
  input  logic              flush,
  output logic [OPND_W-1:0] in1,
  output logic [OPND_W-1:0] in2,
  output logic              op_valid,
  output logic [LVL_W-1:0]  level,
  output logic [15:0]       issued
);

  opnd_pair_t head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  // Readiness looks only at the registered level, never at a same-cycle pop.
  assign s_ready = !full && rst && !flush;
  assign push    = s_valid && s_ready;
  assign pop     = issue_en && !empty && !flush;

  sub_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (opnd_pair_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ('{a: s_in1, b: s_in2}),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // in1/in2 hold their last issued values whenever nothing is popped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in1      <= '0;
      in2      <= '0;
      op_valid <= 1'b0;
      issued   <= '0;
    end else begin
      op_valid <= pop;
      if (pop) begin
        in1    <= head.a;
        in2    <= head.b;
        issued <= issued + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sub_operand_feeder.sv
// Directed bench for sub_operand_feeder: reset, latency, full/backpressure,
// push+pop at full, flush, mid-stream reset and issued-counter wrap.
module tb_sub_operand_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_in1;
  logic [7:0] s_in2;
  logic       issue_en;
  logic       flush;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       op_valid;
  logic [3:0] level;
  logic [15:0] issued;

  int n_checks = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  sub_operand_feeder #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_in1    (s_in1),
    .s_in2    (s_in2),
    .issue_en (issue_en),
    .flush    (flush),
    .in1      (in1),
    .in2      (in2),
    .op_valid (op_valid),
    .level    (level),
    .issued   (issued)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Advance one posedge and settle 1 time unit past it; drive and sample here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill8(input int base1, input int base2);
    issue_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_in1   = 8'(base1 + i);
      s_in2   = 8'(base2 + i);
      step();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_in1 = '0; s_in2 = '0; issue_en = 1'b0; flush = 1'b0;

    // 1: reset
    step(); step();
    check("rst_in1", in1, 0);
    check("rst_in2", in2, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_level", level, 0);
    check("rst_issued", issued, 0);
    check("rst_s_ready_low", s_ready, 0);
    rst = 1'b1;
    #1;
    check("s_ready_after_rst", s_ready, 1);

    // 2: single pair, two-edge latency
    s_valid = 1'b1; s_in1 = 8'd20; s_in2 = 8'd5; issue_en = 1'b1;
    step();
    s_valid = 1'b0;
    check("lat_no_bypass", op_valid, 0);
    check("lat_level1", level, 1);
    step();
    check("lat_op_valid", op_valid, 1);
    check("lat_in1", in1, 20);
    check("lat_in2", in2, 5);
    check("lat_issued", issued, 1);
    check("lat_level0", level, 0);
    step();
    check("lat_pulse_one_cycle", op_valid, 0);
    check("lat_hold_in1", in1, 20);

    // 3: fill to full, reject 9th, drain in order
    fill8(0, 1);
    check("full_level", level, 8);
    check("full_s_ready", s_ready, 0);
    s_valid = 1'b1; s_in1 = 8'd99; s_in2 = 8'd99;
    step();
    s_valid = 1'b0;
    check("full_9th_rejected", level, 8);
    issue_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("drain_valid_%0d", i), op_valid, 1);
      check($sformatf("drain_in1_%0d", i), in1, i);
      check($sformatf("drain_in2_%0d", i), in2, i + 1);
    end
    check("drain_issued", issued, 9);
    check("drain_level", level, 0);
    step();
    check("drain_idle", op_valid, 0);

    // 4: at full, pop cycle takes no push, then steady push+pop holds level 7
    fill8(100, 150);
    s_valid = 1'b1; s_in1 = 8'd200; s_in2 = 8'd210; issue_en = 1'b1;
    step();
    check("fullpop_level7", level, 7);
    check("fullpop_in1", in1, 100);
    step();  // 200 accepted now, 101 issued
    check("steady_level_a", level, 7);
    check("steady_in1_a", in1, 101);
    s_in1 = 8'd201; s_in2 = 8'd211;
    step();
    s_valid = 1'b0;
    check("steady_level_b", level, 7);
    check("steady_in1_b", in1, 102);
    check("steady_issued", issued, 12);

    // 5: drain to level 5, then flush with a dropped push
    step(); step();  // issues 103, 104
    issue_en = 1'b0;
    check("preflush_level", level, 5);
    flush = 1'b1; s_valid = 1'b1; s_in1 = 8'd77; s_in2 = 8'd77;
    #1;
    check("flush_s_ready", s_ready, 0);
    step();
    flush = 1'b0; s_valid = 1'b0;
    check("flush_level", level, 0);
    check("flush_op_valid", op_valid, 0);
    check("flush_hold_in1", in1, 104);
    check("flush_hold_in2", in2, 154);
    check("flush_issued", issued, 14);
    s_valid = 1'b1; s_in1 = 8'd7; s_in2 = 8'd3; issue_en = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    check("postflush_in1", in1, 7);
    check("postflush_in2", in2, 3);

    // 6: reset mid-stream at level 3, then issued wrap
    issue_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_in1 = 8'(i + 50); s_in2 = 8'(i + 60);
      step();
    end
    s_valid = 1'b0;
    check("prerst_level", level, 3);
    rst = 1'b0;
    step();
    check("midrst_level", level, 0);
    check("midrst_issued", issued, 0);
    check("midrst_in1", in1, 0);
    check("midrst_op_valid", op_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    rst = 1'b1;
    #1;
    check("midrst_s_ready_back", s_ready, 1);

    issue_en = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      s_valid = 1'b1; s_in1 = 8'(k); s_in2 = ~8'(k);
      step();
    end
    s_valid = 1'b0;
    check("wrap_pre_issued", issued, 16'hFFFF);
    check("wrap_pre_level", level, 1);
    step();
    check("wrap_issued", issued, 0);
    check("wrap_op_valid", op_valid, 1);
    check("wrap_in1", in1, 8'hFF);
    check("wrap_in2", in2, 8'h00);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
